// File: rtl/main_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : main_bridge
//  Description : Fetches a 64-bit line as two 32-bit bus beats on a rising
//                edge of doMainFetch; per-beat ack timeout reports an error.
//                Define MAIN_BRIDGE_LINEBUF_EN for a one-entry last-line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_bridge #(
    parameter int ADDRESS_LENGTH = 56,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      doMainFetch,
    input  logic [ADDRESS_LENGTH-1:0] mainAddress,
    output logic [63:0]               mainData,
    output logic                      mainReady,
    output logic                      mainError,
    output logic                      busReq,
    output logic [ADDRESS_LENGTH-1:0] busAddress,
    input  logic                      busAck,
    input  logic [31:0]               busData
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0]                c_timeout   = 8'(TIMEOUT_CYCLES);
    localparam logic [ADDRESS_LENGTH-1:0] c_beat_mask = ADDRESS_LENGTH'(7);
    localparam logic [ADDRESS_LENGTH-1:0] c_hi_beat   = ADDRESS_LENGTH'(4);

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic                      r_fetch_d;
    logic                      r_seen_low;
    logic                      r_err;
    logic [7:0]                r_wait;
    logic                      w_edge;
    logic                      w_hit;
    logic                      w_start;
    logic                      w_beat;
    logic                      w_timeout;
    logic [ADDRESS_LENGTH-1:0] w_aligned;

    // r_seen_low blocks a level held high across reset release from starting
    assign w_edge    = doMainFetch & ~r_fetch_d & r_seen_low;
    assign w_aligned = mainAddress & ~c_beat_mask;
    assign mainReady = (r_state == S_DONE);
    assign mainError = (r_state == S_DONE) & r_err;

`ifdef MAIN_BRIDGE_LINEBUF_EN
    logic                      r_lb_valid;
    logic [ADDRESS_LENGTH-4:0] r_lb_tag;

    // Whenever the entry is valid, mainData already holds its line
    assign w_hit = r_lb_valid & (mainAddress[ADDRESS_LENGTH-1:3] == r_lb_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lb_valid <= 1'b0;
            r_lb_tag   <= '0;
        end else if (r_state == S_DONE) begin
            if (r_err) begin
                r_lb_valid <= 1'b0;
            end else begin
                r_lb_valid <= 1'b1;
                r_lb_tag   <= busAddress[ADDRESS_LENGTH-1:3];
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_beat       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_start      = 1'b1;
                    w_state_next = w_hit ? S_DONE : S_LOW;
                end
            end
            S_LOW, S_HIGH: begin
                // An ack in the same cycle as the limit wins over the timeout
                if (busAck) begin
                    w_beat       = 1'b1;
                    w_state_next = (r_state == S_LOW) ? S_HIGH : S_DONE;
                end else if (r_wait == c_timeout) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_d  <= 1'b0;
            r_seen_low <= 1'b0;
            r_wait     <= '0;
            r_err      <= 1'b0;
            busReq     <= 1'b0;
            busAddress <= '0;
            mainData   <= '0;
        end else begin
            r_fetch_d <= doMainFetch;
            if (!doMainFetch) begin
                r_seen_low <= 1'b1;
            end

            if (w_state_next != r_state) begin
                r_wait <= '0;
            end else if ((r_state == S_LOW || r_state == S_HIGH) && !busAck
                         && r_wait != 8'hFF) begin
                r_wait <= r_wait + 8'd1;
            end

            if (w_start && !w_hit) begin
                busAddress <= w_aligned;
                busReq     <= 1'b1;
            end

            if (w_beat) begin
                if (r_state == S_LOW) begin
                    mainData[31:0] <= busData;
                    busAddress     <= busAddress | c_hi_beat;
                end else begin
                    mainData[63:32] <= busData;
                    busReq          <= 1'b0;
                end
            end

            if (w_timeout) begin
                busReq   <= 1'b0;
                mainData <= '0;
                r_err    <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
